i2s_tx: RTL and testbench
=========================

# i2s_tx

I2S master transmitter: accepts 16-bit stereo sample pairs over a valid/ready handshake in the system clock domain and generates `audio_bclk`, `audio_lrclk` and `audio_sdata` as a standard Philips I2S stream. It uses 32-bit slots and 64 BCLK per frame. It is the stage directly upstream of `i2s_rx`, whose `audio_bclk`/`audio_lrclk`/`audio_sdata` inputs it drives, for loopback and for driving external codecs. All three I2S outputs are registered and derived from the single system clock. No second clock domain exists.

## Interface
Parameters:
- `BCLK_DIV`, default 8: system-clock cycles per BCLK half-period. Legal range is ≥2. At 50 MHz this gives 3.125 MHz BCLK and fs ≈ 48.8 kHz.

Ports:
- `clk` in 1: system clock. One clock; all logic runs on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_ldata` in 16: left sample, two's complement.
- `in_rdata` in 16: right sample, two's complement.
- `in_valid` in 1: sample pair is valid.
- `in_ready` out 1: one-entry buffer is empty. Reset value 1.
- `audio_bclk` out 1: bit clock. Reset value 0.
- `audio_lrclk` out 1: word select; 0 = left, 1 = right. Reset value 1.
- `audio_sdata` out 1: serial data, MSB first. Reset value 0.
- `underrun` out 1: one-clk pulse when a frame starts with the buffer empty. Reset value 0.

## Operation
- **Divider:**
  - `div_cnt` counts 0..BCLK_DIV-1.
  - At terminal count it wraps to 0 and `audio_bclk` toggles.
  - A 1→0 toggle is the *fall event* (`fall_stb`, internal, one clk wide).
- **Bit counter:**
  - `bit_cnt`, 6 bits, reset value 63. It increments on each fall event and wraps 63→0.
  - `audio_lrclk` = `bit_cnt[5]`, i.e. 0 for 0..31 and 1 for 32..63.
- **Frame load:**
  - A frame load occurs on the fall event where `bit_cnt` wraps 63→0.
  - If the buffer is full: `shift_l`/`shift_r` ← buffer, and the buffer empties.
  - Otherwise: `shift_l`/`shift_r` ← 0 and `underrun` pulses that cycle.
- **Data mapping:** `p` = `bit_cnt[4:0]`, the position within the slot.
  - `audio_sdata` = `slot_data[16-p]` for p = 1..16, and 0 for p = 0 and p = 17..31.
  - This gives the I2S one-BCLK delay after an LRCLK change. The MSB is at p=1 and the LSB at p=16.
- **Output update:** `audio_bclk`, `audio_lrclk` and `audio_sdata` all update on the same clk edge as the fall event. Only `audio_bclk` changes on rising toggles.
- **Handshake:**
  - Accept = `in_valid & in_ready`. The buffer captures both channels and becomes full.
  - `in_ready` = `!buf_full`, registered.
  - Data must be held stable while `in_valid & !in_ready`.
- **Simultaneous accept and frame load on the same clk:**
  - Buffer full before that clk: the old buffer goes to the shifters and the new pair goes to the buffer, which stays full.
  - Buffer empty before that clk: the frame underruns (zeros, `underrun` pulses) and the new pair goes to the buffer.
- **Reset mid-operation:** all state is cleared asynchronously to the reset values, the buffered sample is discarded, and the divider restarts at 0.

## Timing
- BCLK period = 2·BCLK_DIV clk cycles. Frame = 64 BCLK = 128·BCLK_DIV clk cycles.
- After reset release:
  - first BCLK rise at clk cycle BCLK_DIV;
  - first fall at cycle 2·BCLK_DIV, which is also the first frame load; `audio_lrclk` goes 1→0 there;
  - first MSB on `audio_sdata` one BCLK later.
- Latency from accept to left MSB on `audio_sdata` = time to the next frame load + 2·BCLK_DIV clk cycles.
- Throughput: one sample pair per frame. `in_ready` rises on the clk after the frame load that empties the buffer.
- Receiver view: data is stable around every BCLK rising edge, having changed BCLK_DIV clk cycles earlier.

## Structure
- Shared package `i2s_pkg`:
  - `SAMPLE_W` = 16, `SLOT_BITS` = 32, `FRAME_BITS` = 64.
  - Parameter check: BCLK_DIV ≥ 2.
- Sub-module `i2s_bclk_gen`: divider plus `bclk`/`fall_stb` generation. It is reused by a future `i2s_rx` master-mode wrapper.
- `i2s_tx` contains the bit counter, sample buffer, shifters and output registers.

## Test plan
- **Reset:** hold `rst_n`=0 → `audio_bclk`=0, `audio_lrclk`=1, `audio_sdata`=0, `in_ready`=1, `underrun`=0. Release with BCLK_DIV=2 → BCLK period of 4 clk; `audio_lrclk` falls at clk 4.
- **Single frame:** send L=16'hA5C3, R=16'h3C5A before the first frame load → on BCLK rises, sdata reads 0, A5C3 MSB-first, 15 zeros, 0, 3C5A MSB-first, 15 zeros.
- **Loopback:** drive `i2s_rx` from the outputs and stream 8 pairs (L=16'h0001<<k, R=~L) → `i2s_rx` `audio_ldata`/`audio_rdata` match each pair, in order, one frame later.
- **Underrun:** no `in_valid` for 2 frames → `audio_sdata` stays 0 for 128 BCLK, and `underrun` pulses exactly twice, one clk each, at the frame loads.
- **Back-pressure:** hold `in_valid`=1 with an incrementing pair → `in_ready` is low except for one clk per frame; every pair appears exactly once; none is lost or duplicated.
- **Mid-frame reset:** assert `rst_n` at `bit_cnt`=20 of the left slot → outputs return to reset values immediately; the buffered pair is discarded (`in_ready`=1); the next frame underruns unless new data is sent.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmit/receive blocks.
// Frame geometry is fixed: 16-bit samples in 32-bit slots, 64 bit clocks per frame.
package i2s_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int POS_W      = $clog2(SLOT_BITS);
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  function automatic bit bclk_div_ok(input int div);
    return div >= 2;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV system clocks and flags the
// cycle on which bclk is about to fall so callers can update data on that edge.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall_stb
);

  localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic             tc;

  assign tc       = (div_cnt == CNT_W'(BCLK_DIV - 1));
  assign fall_stb = tc & bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S master transmitter: one-entry stereo buffer feeding 32-bit slots,
// with bclk, lrclk and sdata all registered in the system clock domain.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] in_ldata,
  input  logic [SAMPLE_W-1:0] in_rdata,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                audio_bclk,
  output logic                audio_lrclk,
  output logic                audio_sdata,
  output logic                underrun
);

  generate
    if (!bclk_div_ok(BCLK_DIV)) begin : g_bad_div
      $error("i2s_tx: BCLK_DIV must be at least 2");
    end
  endgenerate

  logic                       bclk;
  logic                       fall_stb;
  logic [BIT_CNT_W-1:0]       bit_cnt;
  logic [BIT_CNT_W-1:0]       bit_nxt;
  logic                       frame_load;
  logic                       accept;
  logic                       buf_full;
  logic                       buf_full_nxt;
  logic signed [SAMPLE_W-1:0] buf_l;
  logic signed [SAMPLE_W-1:0] buf_r;
  logic signed [SAMPLE_W-1:0] shift_l;
  logic signed [SAMPLE_W-1:0] shift_r;

  // Slot position p carries sample bit 16-p for p=1..16; p=0 is the I2S one-bit delay.
  function automatic logic slot_bit(input logic signed [SAMPLE_W-1:0] s,
                                    input logic [POS_W-1:0] p);
    logic [POS_W-1:0] idx;
    idx = POS_W'(SAMPLE_W) - p;
    if ((p != '0) && (p <= POS_W'(SAMPLE_W)))
      return s[idx[$clog2(SAMPLE_W)-1:0]];
    else
      return 1'b0;
  endfunction

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .bclk     (bclk),
    .fall_stb (fall_stb)
  );

  assign bit_nxt      = bit_cnt + 1'b1;
  assign frame_load   = fall_stb & (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
  assign accept       = in_valid & in_ready;
  assign buf_full_nxt = accept | (buf_full & ~frame_load);
  assign audio_bclk   = bclk;
  assign audio_lrclk  = bit_cnt[BIT_CNT_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= BIT_CNT_W'(FRAME_BITS - 1);
      buf_full    <= 1'b0;
      in_ready    <= 1'b1;
      underrun    <= 1'b0;
      audio_sdata <= 1'b0;
    end else begin
      buf_full <= buf_full_nxt;
      in_ready <= ~buf_full_nxt;
      underrun <= frame_load & ~buf_full;
      if (fall_stb) begin
        bit_cnt     <= bit_nxt;
        audio_sdata <= slot_bit(bit_nxt[BIT_CNT_W-1] ? shift_r : shift_l,
                                bit_nxt[POS_W-1:0]);
      end
    end
  end

  // Sample storage carries no reset; validity is tracked by buf_full alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_l <= $signed(in_ldata);
      buf_r <= $signed(in_rdata);
    end
    if (frame_load) begin
      shift_l <= buf_full ? buf_l : '0;
      shift_r <= buf_full ? buf_r : '0;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a serial receiver model decodes the I2S stream
// and checks it against a scoreboard of accepted sample pairs.
module tb_i2s_tx;

  localparam int BCLK_DIV   = 2;
  localparam int FRAME_CLKS = 128 * BCLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_ldata = '0;
  logic [15:0] in_rdata = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        audio_bclk;
  logic        audio_lrclk;
  logic        audio_sdata;
  logic        underrun;

  i2s_tx #(.BCLK_DIV(BCLK_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_ldata    (in_ldata),
    .in_rdata    (in_rdata),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .audio_bclk  (audio_bclk),
    .audio_lrclk (audio_lrclk),
    .audio_sdata (audio_sdata),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  // receiver model state
  bit          framing = 0;
  logic [5:0]  rx_pos = '0;
  logic [4:0]  m_p;
  logic        prev_bclk = 1'b0;
  logic        prev_lr = 1'b1;
  logic        m_load;
  logic        m_exp_ur;
  int          cyc = 0;
  logic [15:0] cur_l = '0, cur_r = '0, word = '0;
  logic        pad = 1'b0;
  int          frames_done = 0;
  int          ur_seen = 0;
  int          pops = 0;

  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        exp_q.delete();
        framing   = 0;
        cyc       = 0;
        prev_bclk = 1'b0;
        prev_lr   = 1'b1;
      end else begin
        cyc++;
        m_load   = prev_lr && !audio_lrclk;
        m_exp_ur = 1'b0;
        if (audio_bclk !== prev_bclk) begin
          n_checks++;
          if (cyc != BCLK_DIV) begin
            n_fail++;
            $display("FAIL bclk_half_period: got %0d clk, expected %0d", cyc, BCLK_DIV);
          end
          cyc = 0;
          if (!prev_bclk) begin
            if (framing) begin
              n_checks++;
              if (audio_lrclk !== rx_pos[5]) begin
                n_fail++;
                $display("FAIL lrclk_at_rise: pos %0d got %b expected %b", rx_pos, audio_lrclk, rx_pos[5]);
              end
              m_p = rx_pos[4:0];
              if (m_p == 0) begin
                word = '0;
                pad  = audio_sdata;
              end else if (m_p <= 16) begin
                word = {word[14:0], audio_sdata};
              end else begin
                pad = pad | audio_sdata;
              end
              if (m_p == 16) begin
                n_checks++;
                if (word !== (rx_pos[5] ? cur_r : cur_l)) begin
                  n_fail++;
                  $display("FAIL %s_word: got %h expected %h", rx_pos[5] ? "right" : "left",
                           word, rx_pos[5] ? cur_r : cur_l);
                end
              end
              if (m_p == 31) begin
                n_checks++;
                if (pad !== 1'b0) begin
                  n_fail++;
                  $display("FAIL slot_padding: got %b expected 0 (pos %0d)", pad, rx_pos);
                end
                if (rx_pos[5]) frames_done++;
              end
            end
          end else begin
            if (m_load) begin
              framing = 1;
              rx_pos  = '0;
              if (exp_q.size() > 0) begin
                {cur_l, cur_r} = exp_q.pop_front();
                pops++;
              end else begin
                cur_l    = '0;
                cur_r    = '0;
                m_exp_ur = 1'b1;
              end
            end else if (framing) begin
              rx_pos = rx_pos + 6'd1;
            end
          end
        end else if (m_load) begin
          n_checks++;
          n_fail++;
          $display("FAIL lrclk_edge: lrclk fell without a bclk fall, got bclk %b expected 1->0", audio_bclk);
        end
        n_checks++;
        if (underrun !== m_exp_ur) begin
          n_fail++;
          $display("FAIL underrun_pulse: got %b expected %b", underrun, m_exp_ur);
        end
        if (underrun === 1'b1) ur_seen++;
        prev_bclk = audio_bclk;
        prev_lr   = audio_lrclk;
        #2;
        if (rst_n) begin
          n_checks++;
          if (in_ready !== (exp_q.size() == 0)) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_q.size() == 0);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_pair(input logic [15:0] l, input logic [15:0] r);
    int t = 0;
    bit acc = 0;
    @(negedge clk);
    in_ldata = l;
    in_rdata = r;
    in_valid = 1'b1;
    while (!acc && t < 2 * FRAME_CLKS) begin
      acc = in_ready;
      @(posedge clk); #2;
      if (acc) exp_q.push_back({l, r});
      t++;
      if (!acc) @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept in %0d clk, expected one", t);
    end
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int t = 0;
    while (frames_done < target && t < (n + 1) * FRAME_CLKS) begin
      @(posedge clk); #2;
      t++;
    end
    n_checks++;
    if (frames_done < target) begin
      n_fail++;
      $display("FAIL frame_timeout: got %0d frames, expected %0d", frames_done, target);
    end
  endtask

  task automatic wait_empty();
    int t = 0;
    while (exp_q.size() != 0 && t < 4 * FRAME_CLKS) begin
      @(posedge clk); #2;
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d queued, expected 0", exp_q.size());
    end
  endtask

  task automatic wait_pos(input logic [5:0] pos);
    int t = 0;
    while (!(framing && rx_pos == pos) && t < 2 * FRAME_CLKS) begin
      @(posedge clk); #2;
      t++;
    end
    n_checks++;
    if (!(framing && rx_pos == pos)) begin
      n_fail++;
      $display("FAIL pos_timeout: got pos %0d, expected %0d", rx_pos, pos);
    end
  endtask

  task automatic test_reset();
    int k;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 5;
    if (audio_bclk !== 1'b0)  begin n_fail++; $display("FAIL rst_bclk: got %b expected 0", audio_bclk); end
    if (audio_lrclk !== 1'b1) begin n_fail++; $display("FAIL rst_lrclk: got %b expected 1", audio_lrclk); end
    if (audio_sdata !== 1'b0) begin n_fail++; $display("FAIL rst_sdata: got %b expected 0", audio_sdata); end
    if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    if (underrun !== 1'b0)    begin n_fail++; $display("FAIL rst_underrun: got %b expected 0", underrun); end
    @(negedge clk);
    rst_n = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (audio_lrclk === 1'b0) break;
    end
    n_checks++;
    if (k != 2 * BCLK_DIV) begin
      n_fail++;
      $display("FAIL lrclk_first_fall: got clk %0d expected %0d", k, 2 * BCLK_DIV);
    end
    wait_frames(1);
  endtask

  task automatic test_single_frame();
    int p0;
    do_reset();
    p0 = pops;
    drive_pair(16'hA5C3, 16'h3C5A);
    wait_frames(1);
    n_checks++;
    if (pops - p0 != 1) begin
      n_fail++;
      $display("FAIL single_frame_count: got %0d frames with data, expected 1", pops - p0);
    end
  endtask

  task automatic test_loopback();
    int p0 = pops;
    logic [15:0] l;
    for (int k = 0; k < 8; k++) begin
      l = 16'h0001 << k;
      drive_pair(l, ~l);
    end
    wait_empty();
    wait_frames(1);
    n_checks++;
    if (pops - p0 != 8) begin
      n_fail++;
      $display("FAIL loopback_count: got %0d pairs, expected 8", pops - p0);
    end
  endtask

  task automatic test_underrun();
    int u0, p0;
    wait_frames(1);
    u0 = ur_seen;
    p0 = pops;
    wait_frames(2);
    n_checks += 2;
    if (ur_seen - u0 != 2) begin
      n_fail++;
      $display("FAIL underrun_count: got %0d pulses, expected 2", ur_seen - u0);
    end
    if (pops - p0 != 0) begin
      n_fail++;
      $display("FAIL underrun_data: got %0d data frames, expected 0", pops - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pops;
    for (int k = 0; k < 6; k++)
      drive_pair(16'h1000 + 16'(k), 16'hF000 - 16'(k));
    wait_empty();
    wait_frames(1);
    n_checks++;
    if (pops - p0 != 6) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d pairs, expected 6", pops - p0);
    end
  endtask

  task automatic test_mid_frame_reset();
    int u0, p0;
    wait_pos(6'd4);
    drive_pair(16'h1234, 16'h5678);
    wait_pos(6'd20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (audio_bclk !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_bclk: got %b expected 0", audio_bclk); end
    if (audio_lrclk !== 1'b1) begin n_fail++; $display("FAIL mid_rst_lrclk: got %b expected 1", audio_lrclk); end
    if (audio_sdata !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sdata: got %b expected 0", audio_sdata); end
    if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
    if (underrun !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_underrun: got %b expected 0", underrun); end
    repeat (2) @(negedge clk);
    u0 = ur_seen;
    p0 = pops;
    rst_n = 1'b1;
    wait_frames(1);
    n_checks += 2;
    if (ur_seen - u0 != 1) begin
      n_fail++;
      $display("FAIL mid_rst_underrun_count: got %0d pulses, expected 1", ur_seen - u0);
    end
    if (pops - p0 != 0) begin
      n_fail++;
      $display("FAIL mid_rst_discard: got %0d data frames, expected 0", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_loopback();
    test_underrun();
    test_back_to_back();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
